// File: rtl/cascade_pulse_counter_pkg.sv
// cascade_pulse_counter_pkg: slow-stage mode codes and parameter legality check
package cascade_pulse_counter_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_STOP = 1;
  function automatic bit params_ok(
    input int fast_w,
    input int fast_mod,
    input int slow_w,
    input int slow_init,
    input int pulse_len,
    input int slow_mode
  );
    return fast_w >= 1 && fast_w <= 30 && fast_mod >= 2 && fast_mod <= (1 << fast_w) &&
           slow_w >= 1 && slow_w <= 30 && slow_init >= 0 && slow_init < (1 << slow_w) &&
           pulse_len >= 1 && (slow_mode == MODE_WRAP || slow_mode == MODE_STOP);
  endfunction
endpackage

// File: rtl/cascade_pulse_counter_stretcher.sv
// pulse_stretcher: holds pulse high for LEN cycles after trig, retriggerable
module pulse_stretcher #(
  parameter int LEN   = 2,
  parameter int CNT_W = $clog2(LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic trig,
  output logic pulse
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      cnt   <= trig ? CNT_W'(LEN) : (cnt != '0 ? cnt - 1'b1 : cnt);
      pulse <= trig || cnt > CNT_W'(1);
    end
endmodule

// File: rtl/cascade_pulse_counter.sv
// cascade_pulse_counter: fast modulo stage decrementing a slow stage, with tick and stretched led
module cascade_pulse_counter
  import cascade_pulse_counter_pkg::*;
#(
  parameter int FAST_W    = 4,
  parameter int FAST_MOD  = 13,
  parameter int SLOW_W    = 4,
  parameter int SLOW_INIT = 15,
  parameter int PULSE_LEN = 2,
  parameter int SLOW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  output logic [FAST_W-1:0] fast_count,
  output logic [SLOW_W-1:0] slow_count,
  output logic              tick,
  output logic              led,
  output logic              done
);
  localparam logic [FAST_W-1:0] FAST_LAST   = FAST_W'(FAST_MOD - 1);
  localparam logic [SLOW_W-1:0] SLOW_RELOAD = SLOW_W'(SLOW_INIT);
  localparam bit                STOP        = SLOW_MODE == MODE_STOP;
  if (!params_ok(FAST_W, FAST_MOD, SLOW_W, SLOW_INIT, PULSE_LEN, SLOW_MODE)) begin : g_bad_params
    $error("cascade_pulse_counter: illegal parameter set");
  end
  logic adv, wrap;
  always_comb begin
    adv  = en && !done;
    wrap = adv && fast_count == FAST_LAST;
  end
  always_ff @(posedge clk)
    if (rst || clr) begin
      fast_count <= '0;
      slow_count <= SLOW_RELOAD;
      tick       <= 1'b0;
      done       <= 1'b0;
    end else begin
      fast_count <= wrap ? '0 : (adv ? fast_count + 1'b1 : fast_count);
      if (wrap) slow_count <= slow_count != '0 ? slow_count - 1'b1 : (STOP ? '0 : SLOW_RELOAD);
      done       <= done || (STOP && wrap && slow_count == '0);
      tick       <= wrap;
    end
  pulse_stretcher #(.LEN(PULSE_LEN)) u_stretch (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .trig (wrap),
    .pulse(led)
  );
endmodule

// File: tb/tb_cascade_pulse_counter.sv
// tb_cascade_pulse_counter: directed vector table plus multi-cycle sequences over four configurations
module tb_cascade_pulse_counter;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, clr = 1'b0;
  logic [3:0] f0, s0, f1, s1, f2, s2, f3, s3;
  logic t0, l0, d0, t1, l1, d1, t2, l2, d2, t3, l3, d3;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  cascade_pulse_counter u_def (.clk(clk), .rst(rst), .en(en), .clr(clr),
    .fast_count(f0), .slow_count(s0), .tick(t0), .led(l0), .done(d0));
  cascade_pulse_counter #(.SLOW_MODE(1), .SLOW_INIT(1), .FAST_MOD(3)) u_stop (.clk(clk), .rst(rst),
    .en(en), .clr(clr), .fast_count(f1), .slow_count(s1), .tick(t1), .led(l1), .done(d1));
  cascade_pulse_counter #(.PULSE_LEN(8), .FAST_MOD(4)) u_retrig (.clk(clk), .rst(rst), .en(en),
    .clr(clr), .fast_count(f2), .slow_count(s2), .tick(t2), .led(l2), .done(d2));
  cascade_pulse_counter #(.FAST_MOD(16), .SLOW_INIT(0)) u_full (.clk(clk), .rst(rst), .en(en),
    .clr(clr), .fast_count(f3), .slow_count(s3), .tick(t3), .led(l3), .done(d3));

  typedef struct {
    logic       en;
    logic       clr;
    logic [3:0] fast;
    logic [3:0] slow;
    logic       tick;
    logic       led;
    logic       done;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic e, input logic c);
    en  = e;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en  = 1'b0;
    clr = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 1; i <= 12; i++) vecs.push_back('{1'b1, 1'b0, 4'(i), 4'd15, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'd0, 4'd14, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0});
    for (int k = 1; k <= 25; k++) vecs.push_back('{k % 2 == 0, 1'b0, 4'(k / 2), 4'd15, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'd0, 4'd14, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd14, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'd1, 4'd14, 1'b0, 1'b0, 1'b0});

    do_reset();
    check("rst fast", f0, 0);
    check("rst slow", s0, 15);
    check("rst tick", t0, 0);
    check("rst led", l0, 0);
    check("rst done", d0, 0);
    check("rst stop slow", s1, 1);
    check("rst full slow", s3, 0);

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].clr);
      check($sformatf("vec%0d fast", i), f0, vecs[i].fast);
      check($sformatf("vec%0d slow", i), s0, vecs[i].slow);
      check($sformatf("vec%0d tick", i), t0, vecs[i].tick);
      check($sformatf("vec%0d led", i), l0, vecs[i].led);
      check($sformatf("vec%0d done", i), d0, vecs[i].done);
    end

    do_reset();
    for (int k = 1; k <= 16 * 13; k++) begin
      step(1'b1, 1'b0);
      check("wrapmode done", d0, 0);
      if (k % 13 == 0) begin
        check($sformatf("wrap%0d tick", k / 13), t0, 1);
        check($sformatf("wrap%0d slow", k / 13), s0, k == 208 ? 15 : 15 - k / 13);
      end
      if (k == 15) check("full fast15", f3, 15);
      if (k % 16 == 0) begin
        check("full tick", t3, 1);
        check("full fast", f3, 0);
        check("full slow", s3, 0);
      end
    end

    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("stop e3 slow", s1, 0);
    check("stop e3 tick", t1, 1);
    check("stop e3 done", d1, 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("stop e5 done", d1, 0);
    step(1'b1, 1'b0);
    check("stop e6 done", d1, 1);
    check("stop e6 fast", f1, 0);
    check("stop e6 tick", t1, 1);
    check("stop e6 slow", s1, 0);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
    check("stop frozen fast", f1, 0);
    check("stop frozen slow", s1, 0);
    check("stop frozen tick", t1, 0);
    check("stop frozen done", d1, 1);
    step(1'b1, 1'b1);
    check("stop clr done", d1, 0);
    check("stop clr slow", s1, 1);
    check("stop clr fast", f1, 0);
    step(1'b1, 1'b0);
    check("stop resume fast", f1, 1);

    do_reset();
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 1'b0);
      check($sformatf("retrig e%0d led", k), l2, k >= 4);
    end
    rst = 1'b1;
    step(1'b1, 1'b0);
    rst = 1'b0;
    check("retrig rst led", l2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
